uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Oversampling UART receiver, successor to the single-sample receiver. Adds a baud sample-tick divider,
//  mid-bit sampling, a start-bit glitch filter and per-frame parity/framing/break flags.
//  Frames are buffered in a small receive FIFO with a valid/ready pop handshake and overrun reporting.
//  Sits between the synchronised rx pad and the APB UART register block.
// PARAMETERS
//  DATA_BITS        8   data bits per frame, legal 5..9, sent LSB first
//  PARITY_EN        0   0 = none, 1 = odd, 2 = even
//  STOP_BITS        1   stop bits, 1 or 2
//  OVERSAMPLE       16  sample ticks per bit, even, >= 8
//  CLKS_PER_SAMPLE  27  clk cycles per sample tick (27 gives 50 MHz / 115200 / 16)
//  FIFO_DEPTH       8   receive FIFO entries, power of 2, >= 2
// PORTS
//  clk         in   1                     system clock
//  rst         in   1                     synchronous, active-high reset
//  rx          in   1                     serial line, asynchronous, idles high
//  rx_data     out  DATA_BITS             data of the FIFO head entry
//  rx_perr     out  1                     parity error flag of the head entry
//  rx_ferr     out  1                     framing error flag of the head entry
//  rx_brk      out  1                     break flag of the head entry
//  rx_valid    out  1                     FIFO not empty
//  rx_ready    in   1                     consumer pops the head when rx_valid && rx_ready
//  overrun     out  1                     1-clk pulse when a completed frame is dropped because the FIFO is full
//  busy        out  1                     FSM not in IDLE
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, synchroniser flops 1, armed = 0.
//    Reset taken mid-frame discards the partial frame.
//  rx passes through a 2-flop synchroniser (rxs). The FSM re-arms only after rxs has been sampled
//    high on one tick, so a line held low through reset does not start a frame.
//  Tick divider: counts 0..CLKS_PER_SAMPLE-1 and pulses tick on the terminal count.
//    Restarted at 0 when IDLE detects rxs == 0 while armed.
//  os_cnt counts 0..OVERSAMPLE-1 ticks within a bit. Bit value is sampled at os_cnt == OVERSAMPLE/2.
//  FSM (uart_rx_state_e):
//    IDLE   -> START  when armed && rxs == 0; os_cnt = 0.
//    START  at the mid sample: if rxs == 1, glitch -> IDLE; no flag, nothing pushed.
//           Otherwise continue; at os_cnt == OVERSAMPLE-1 -> DATA.
//    DATA   shifts in DATA_BITS mid-samples. After the last one -> PARITY (PARITY_EN != 0) or STOP.
//    PARITY perr = (^data ^ pbit) != (PARITY_EN == 1).
//    STOP   a 0 on any stop-bit mid sample sets ferr.
//           At the mid sample of the final stop bit: push the entry and go to IDLE in the same cycle.
//           Leaving half a bit early lets the receiver resync to back-to-back frames.
//  brk = ferr && (data == 0) && (pbit == 0 or no parity).
//  FIFO entry = {brk, ferr, perr, data}. First-word-fall-through: rx_valid rises 1 clk after the push cycle.
//  Pop takes effect on clk when rx_valid && rx_ready. A pop while empty is ignored.
//  Push while full with no pop: frame dropped, overrun pulses, contents unchanged.
//  Push while full with a pop in the same cycle: push accepted, fifo_count unchanged.
//  Pointers wrap modulo FIFO_DEPTH. fifo_count is exact from 0 to FIFO_DEPTH.
// CONFIGURATION
//  `UART_RX_MAJORITY_EN defined: each bit (start bit included) is the 2-of-3 majority of the samples at
//    os_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is made at OVERSAMPLE/2+1.
//    Final-stop exit to IDLE moves to that tick.
//  Not defined: single sample at OVERSAMPLE/2. The 3-sample shift register is not built.
// STRUCTURE
//  shared_pkg: uart_rx_state_e {IDLE, START, DATA, PARITY, STOP}, parity_mode_e {PAR_NONE, PAR_ODD, PAR_EVEN},
//    and the uart_rx_entry_t packed struct.
//  Sub-module uart_rx_fifo: generic synchronous FWFT FIFO (WIDTH, DEPTH) with push/pop, full, empty, count.
//  Tick divider, synchroniser and FSM stay in uart_rx_os.
// TESTING  (CLKS_PER_SAMPLE = 4, OVERSAMPLE = 16, so 64 clk per bit)
//  1. 8N1: a 24-clk low glitch on an idle line, then frame 0xA5 -> the glitch yields no entry and busy
//     returns to 0. The frame gives rx_data = 0xA5, flags 0, fifo_count = 1.
//  2. PARITY_EN = 2: data 0x03 with pbit = 1 -> rx_data = 0x03, rx_perr = 1.
//     The same data with pbit = 0 -> rx_perr = 0.
//  3. 8N1: data 0x00 with the stop bit held low -> rx_ferr = 1, rx_brk = 1.
//     Data 0x81 with the stop bit low -> ferr = 1, brk = 0.
//  4. FIFO_DEPTH = 4, rx_ready = 0: send 0x11..0x55 -> fifo_count = 4 and exactly one overrun pulse.
//     Then rx_ready = 1 pops 0x11, 0x22, 0x33, 0x44 in order.
//  5. Assert rst mid-DATA of 0x5A with rx held low after reset -> all outputs 0, no start.
//     Then release rx high for 1 bit and send 0x3C -> 0x3C received.
//  6. 0xFF with a 4-clk low pulse centred on bit 3's mid tick -> 0xFF with `UART_RX_MAJORITY_EN,
//     0xF7 without it.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, parity modes and the FIFO entry layout.
package shared_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_mode_e;

  // Data is sized for the widest legal frame; narrower builds leave the top bits zero.
  typedef struct packed {
    logic                     brk;
    logic                     ferr;
    logic                     perr;
    logic [MAX_DATA_BITS-1:0] data;
  } uart_rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO with exact occupancy count.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with glitch-filtered start detection and a receive FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around the mid tick.
module uart_rx_os
  import shared_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int PARITY_EN       = 0,
  parameter int STOP_BITS       = 1,
  parameter int OVERSAMPLE      = 16,
  parameter int CLKS_PER_SAMPLE = 27,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_brk,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam parity_mode_e PMODE = parity_mode_e'(PARITY_EN);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int CW  = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [OSW-1:0] SAMPLE_AT = OSW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [OSW-1:0] SAMPLE_AT = OSW'(OVERSAMPLE / 2);
`endif
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_rx_state_e state_q, state_d;
  logic                 sync1, rxs, armed;
  logic [CW-1:0]        clk_cnt;
  logic [OSW-1:0]       os_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pbit, ferr;
  logic                 tick, samp, bit_end, bit_val;
  logic                 start_det, push;
  uart_rx_entry_t       push_entry, head;
  logic                 full, empty;
  logic                 unused_head;

  assign tick    = (clk_cnt == CNT_LAST);
  assign samp    = tick && (os_cnt == SAMPLE_AT);
  assign bit_end = tick && (os_cnt == OS_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_sr;
  always_ff @(posedge clk) begin
    if (rst)       maj_sr <= 2'b11;
    else if (tick) maj_sr <= {maj_sr[0], rxs};
  end
  assign bit_val = maj3(maj_sr[1], maj_sr[0], rxs);
`else
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE:   if (armed && !rxs) begin
                state_d   = START;
                start_det = 1'b1;
              end
      START:  if (samp && bit_val) state_d = IDLE;
              else if (bit_end)    state_d = DATA;
      DATA:   if (bit_end && bit_cnt == LAST_BIT)
                state_d = (PMODE != PAR_NONE) ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      // Leave at the mid sample of the last stop bit to catch a back-to-back start edge.
      STOP:   if (samp && stop_cnt == LAST_STOP) begin
                push    = 1'b1;
                state_d = IDLE;
              end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_entry = '0;
    push_entry.data[DATA_BITS-1:0] = shreg;
    push_entry.ferr = ferr | ~bit_val;
    push_entry.perr = (PMODE != PAR_NONE) && ((^shreg ^ pbit) != (PMODE == PAR_ODD));
    push_entry.brk  = push_entry.ferr && (shreg == '0) && (PMODE == PAR_NONE || !pbit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      armed    <= 1'b0;
      clk_cnt  <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      pbit     <= 1'b0;
      ferr     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      sync1   <= rx;
      rxs     <= sync1;
      clk_cnt <= (start_det || tick) ? '0 : clk_cnt + 1'b1;
      overrun <= push && full && !rx_ready;
      if (state_q == IDLE) begin
        os_cnt   <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        // Re-arm only on a high sample so a line stuck low cannot start frames.
        if (start_det) begin
          armed <= 1'b0;
          ferr  <= 1'b0;
          pbit  <= 1'b0;
        end else if (tick && rxs) begin
          armed <= 1'b1;
        end
      end else if (tick) begin
        os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
        if (samp) begin
          case (state_q)
            DATA:    shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            PARITY:  pbit  <= bit_val;
            STOP:    if (!bit_val) ferr <= 1'b1;
            default: ;
          endcase
        end
        if (bit_end) begin
          if (state_q == DATA) bit_cnt  <= bit_cnt + 1'b1;
          if (state_q == STOP) stop_cnt <= 1'b1;
        end
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH ($bits(uart_rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (rx_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign unused_head = ^head;
  assign busy     = (state_q != IDLE);
  assign rx_valid = !empty;
  assign rx_data  = rx_valid ? head.data[DATA_BITS-1:0] : '0;
  assign rx_perr  = rx_valid && head.perr;
  assign rx_ferr  = rx_valid && head.ferr;
  assign rx_brk   = rx_valid && head.brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench: 8N1 receiver (depth 4) and an even-parity receiver, 64 clk per bit.
module tb_uart_rx_os;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic perr_a, ferr_a, brk_a, valid_a, ovr_a, busy_a;
  logic perr_b, ferr_b, brk_b, valid_b, ovr_b, busy_b;
  logic [2:0] cnt_a, cnt_b;
  int n_checks = 0, n_fail = 0, ovr_pulses = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1), .OVERSAMPLE(16),
               .CLKS_PER_SAMPLE(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
    .rx_brk(brk_a), .rx_valid(valid_a), .rx_ready(rdy_a), .overrun(ovr_a), .busy(busy_a),
    .fifo_count(cnt_a));

  uart_rx_os #(.DATA_BITS(8), .PARITY_EN(2), .STOP_BITS(1), .OVERSAMPLE(16),
               .CLKS_PER_SAMPLE(4), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
    .rx_brk(brk_b), .rx_valid(valid_b), .rx_ready(rdy_b), .overrun(ovr_b), .busy(busy_b),
    .fifo_count(cnt_b));

  always @(negedge clk) if (!rst && ovr_a) ovr_pulses++;

  typedef struct {
    string      name;
    bit         sel;      // 0: 8N1 receiver, 1: even-parity receiver
    logic [7:0] d;
    bit         pbit;
    bit         stopv;
    logic [7:0] exp_d;
    bit         exp_perr, exp_ferr, exp_brk;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v; else rx_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit j of each 64-clk bit period lands on the j-th rising edge; gbit selects a bit to
  // pull low for 4 clk around its mid sample.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                            input bit pbit, input bit stopv, input int gbit);
    logic bits [11];
    int   n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (par) begin bits[9] = pbit; bits[10] = stopv; n = 11; end
    else     begin bits[9] = stopv; n = 10; end
    for (int b = 0; b < n; b++)
      for (int j = 0; j < 64; j++) begin
        @(negedge clk);
        drive(sel, (b == gbit && j >= 34 && j <= 37) ? 1'b0 : bits[b]);
      end
    @(negedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic wait_valid(input bit sel, input string name);
    int k = 0;
    while (!(sel ? valid_b : valid_a) && k < 400) begin @(negedge clk); k++; end
    check({name, "_valid"}, sel ? valid_b : valid_a, 1);
  endtask

  task automatic pop_one(input bit sel);
    @(negedge clk);
    if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    logic [7:0] exp6;
    vecs[0] = '{"a5_8n1",   1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"brk_00",   1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"ferr_81",  1'b0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"par_bad",  1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"par_ok",   1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"par_nobrk",1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    idle(5);
    rst = 1'b0;
    idle(5);
    check("rst_valid", {valid_b, valid_a}, 0);
    check("rst_busy",  {busy_b, busy_a}, 0);
    check("rst_count", {cnt_b, cnt_a}, 0);
    check("rst_data",  {data_b, data_a}, 0);
    check("rst_flags", {perr_a, ferr_a, brk_a, ovr_a, perr_b, ferr_b, brk_b, ovr_b}, 0);
    idle(20);

    // 24-clk start glitch: filtered out at the mid sample.
    rx_a = 1'b0;
    idle(10);
    check("glitch_busy_mid", busy_a, 1);
    idle(14);
    rx_a = 1'b1;
    idle(100);
    check("glitch_busy_end", busy_a, 0);
    check("glitch_no_entry", valid_a, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].sel, vecs[i].pbit, vecs[i].stopv, -1);
      idle(64);
      wait_valid(vecs[i].sel, vecs[i].name);
      check({vecs[i].name, "_data"}, vecs[i].sel ? data_b : data_a, vecs[i].exp_d);
      check({vecs[i].name, "_perr"}, vecs[i].sel ? perr_b : perr_a, vecs[i].exp_perr);
      check({vecs[i].name, "_ferr"}, vecs[i].sel ? ferr_b : ferr_a, vecs[i].exp_ferr);
      check({vecs[i].name, "_brk"},  vecs[i].sel ? brk_b  : brk_a,  vecs[i].exp_brk);
      check({vecs[i].name, "_cnt1"}, vecs[i].sel ? cnt_b  : cnt_a,  1);
      pop_one(vecs[i].sel);
      check({vecs[i].name, "_cnt0"}, vecs[i].sel ? cnt_b : cnt_a, 0);
    end

    // Pop while empty is ignored.
    rdy_a = 1'b1;
    idle(3);
    rdy_a = 1'b0;
    check("empty_pop_cnt", cnt_a, 0);

    // Overrun: five back-to-back frames into a 4-deep FIFO with no consumer.
    ovr_pulses = 0;
    for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i * 17), 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check("ovr_count4", cnt_a, 4);
    check("ovr_pulses", ovr_pulses, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d_valid", i), valid_a, 1);
      check($sformatf("ovr_pop%0d_data", i), data_a, 8'(i * 17));
      pop_one(1'b0);
    end
    check("ovr_drained", cnt_a, 0);

    // Reset mid-DATA of 0x5A, line held low afterwards.
    for (int j = 0; j < 64; j++) begin @(negedge clk); rx_a = 1'b0; end
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 64; j++) begin @(negedge clk); rx_a = (b == 1); end
    rx_a = 1'b1;
    idle(20);
    check("rstmid_busy_pre", busy_a, 1);
    rst  = 1'b1;
    rx_a = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(200);
    check("rstmid_busy", busy_a, 0);
    check("rstmid_valid", valid_a, 0);
    check("rstmid_outs", {data_a, perr_a, ferr_a, brk_a, ovr_a, cnt_a}, 0);
    rx_a = 1'b1;
    idle(64);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
    idle(64);
    wait_valid(1'b0, "rstmid_3c");
    check("rstmid_3c_data", data_a, 8'h3C);
    check("rstmid_3c_cnt", cnt_a, 1);
    pop_one(1'b0);

    // Short low pulse on data bit 3's mid sample.
`ifdef UART_RX_MAJORITY_EN
    exp6 = 8'hFF;
`else
    exp6 = 8'hF7;
`endif
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 4);
    idle(64);
    wait_valid(1'b0, "midglitch");
    check("midglitch_data", data_a, exp6);
    check("midglitch_ferr", ferr_a, 0);
    pop_one(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
